// File: rtl/approx_error_monitor_if.sv
// rtl/approx_error_monitor_if.sv - sample/report handshake bundle for approx_error_monitor
// master drives samples and accepts reports; slave is the monitor.
interface approx_error_monitor_if #(
  parameter int WIDTH       = 32,
  parameter int WINDOW_LOG2 = 4
);
  logic                         start;
  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             y_exact;
  logic [WIDTH-1:0]             y_approx;
  logic                         out_valid;
  logic                         out_ready;
  logic [WIDTH+WINDOW_LOG2:0]   sum_abs_err;
  logic [WINDOW_LOG2:0]         err_count;
  logic [WIDTH:0]               max_abs_err;

  modport master (
    output start, in_valid, y_exact, y_approx, out_ready,
    input  in_ready, out_valid, sum_abs_err, err_count, max_abs_err
  );

  modport slave (
    input  start, in_valid, y_exact, y_approx, out_ready,
    output in_ready, out_valid, sum_abs_err, err_count, max_abs_err
  );
endinterface

// File: rtl/approx_error_monitor.sv
// rtl/approx_error_monitor.sv - windowed absolute-error statistics between exact and approximate products
// Optional max tracking enabled by macro APPROX_ERR_MON_MAX_EN; otherwise max_abs_err is tied to 0.
module approx_error_monitor #(
  parameter int WIDTH       = 32,
  parameter int WINDOW_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  approx_error_monitor_if.slave  bus
);
  localparam int AW = WIDTH + 1;
  localparam int SW = WIDTH + 1 + WINDOW_LOG2;
  localparam int CW = WINDOW_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  state_t                 state_q, state_d;
  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
  logic [SW-1:0]          sum_q, sum_d;
  logic [CW-1:0]          errc_q, errc_d;
  logic [AW-1:0]          diff;
  logic [AW-1:0]          abs_err;
  logic                   accept;

  // Widen by one bit before subtracting so the difference can never overflow.
  assign diff    = {bus.y_exact[WIDTH-1], bus.y_exact} - {bus.y_approx[WIDTH-1], bus.y_approx};
  assign abs_err = diff[AW-1] ? (AW'(0) - diff) : diff;
  assign accept  = (state_q == ACCUM) && !bus.start && bus.in_valid;

`ifdef APPROX_ERR_MON_MAX_EN
  logic [AW-1:0] max_q, max_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    errc_d  = errc_q;
`ifdef APPROX_ERR_MON_MAX_EN
    max_d   = max_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACCUM;
          cnt_d   = '0;
          sum_d   = '0;
          errc_d  = '0;
`ifdef APPROX_ERR_MON_MAX_EN
          max_d   = '0;
`endif
        end
      end
      ACCUM: begin
        if (bus.start) begin
          cnt_d  = '0;
          sum_d  = '0;
          errc_d = '0;
`ifdef APPROX_ERR_MON_MAX_EN
          max_d  = '0;
`endif
        end else if (accept) begin
          cnt_d = cnt_q + WINDOW_LOG2'(1);
          sum_d = sum_q + SW'(abs_err);
          if (abs_err != '0) errc_d = errc_q + CW'(1);
`ifdef APPROX_ERR_MON_MAX_EN
          if (abs_err > max_q) max_d = abs_err;
`endif
          if (cnt_q == '1) state_d = REPORT;
        end
      end
      REPORT: begin
        // start is deliberately ignored here; out_ready alone closes the report.
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      errc_q  <= errc_d;
    end
  end

`ifdef APPROX_ERR_MON_MAX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) max_q <= '0;
    else        max_q <= max_d;
  end
  assign bus.max_abs_err = max_q;
`else
  assign bus.max_abs_err = '0;
`endif

  assign bus.in_ready    = (state_q == ACCUM);
  assign bus.out_valid   = (state_q == REPORT);
  assign bus.sum_abs_err = sum_q;
  assign bus.err_count   = errc_q;
endmodule

// File: tb/tb_approx_error_monitor.sv
// tb/tb_approx_error_monitor.sv - directed self-checking bench for approx_error_monitor (WIDTH=8, WINDOW_LOG2=2)
module tb_approx_error_monitor;
  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  approx_error_monitor_if #(.WIDTH(8), .WINDOW_LOG2(2)) bus ();

  approx_error_monitor #(.WIDTH(8), .WINDOW_LOG2(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef APPROX_ERR_MON_MAX_EN
  localparam bit MAX_ON = 1'b1;
`else
  localparam bit MAX_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int e, input int a);
    bus.in_valid = 1'b1;
    bus.y_exact  = 8'(e);
    bus.y_approx = 8'(a);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic check_report(input string tag, input int sum, input int cnt, input int mx);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_sum"},   32'(bus.sum_abs_err), 32'(sum));
    check({tag, "_count"}, 32'(bus.err_count), 32'(cnt));
    check({tag, "_max"},   32'(bus.max_abs_err), MAX_ON ? 32'(mx) : 32'd0);
  endtask

  initial begin
    tests = 0; failed = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.y_exact = '0; bus.y_approx = '0;
    #12;
    check("rst_in_ready",  32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum",       32'(bus.sum_abs_err), 32'd0);
    check("rst_count",     32'(bus.err_count), 32'd0);
    check("rst_max",       32'(bus.max_abs_err), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // zero-error window
    pulse_start();
    check("accum_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) send(25, 25);
    check("a_not_yet", 32'(bus.out_valid), 32'd0);
    send(25, 25);
    check_report("a", 0, 0, 0);
    check("a_in_ready_report", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("a_idle_valid", 32'(bus.out_valid), 32'd0);
    check("a_idle_ready", 32'(bus.in_ready), 32'd0);

    // mixed signs including the extreme pair
    pulse_start();
    send(-6, -5); send(10, 10); send(-128, 127); send(3, -3);
    check_report("b", 262, 3, 255);

    // REPORT holds against out_ready=0, new samples and start
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.y_exact  = 8'(50 + i);
      bus.y_approx = 8'(0);
      bus.start    = (i == 3);
      tick();
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_ready", 32'(bus.in_ready), 32'd0);
      check("hold_sum",   32'(bus.sum_abs_err), 32'd262);
      check("hold_count", 32'(bus.err_count), 32'd3);
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0; bus.out_ready = 1'b0;
    check("b_exit_valid", 32'(bus.out_valid), 32'd0);
    check("b_exit_no_accum", 32'(bus.in_ready), 32'd0);
    tick();
    check("b_still_idle", 32'(bus.in_ready), 32'd0);

    // bubbles between samples
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("c_not_yet", 32'(bus.out_valid), 32'd0);
      send(4, 2);
      if (i < 3) tick();
    end
    check_report("c", 8, 4, 2);
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;

    // restart mid-window; sample presented with start is dropped
    pulse_start();
    send(7, 0); send(0, 7);
    bus.in_valid = 1'b1; bus.y_exact = 8'd100; bus.y_approx = 8'd0;
    pulse_start();
    bus.in_valid = 1'b0;
    check("d_cleared_sum", 32'(bus.sum_abs_err), 32'd0);
    send(-1, 0); send(1, 0); send(0, 1);
    check("d_not_yet", 32'(bus.out_valid), 32'd0);
    send(5, 6);
    check_report("d", 4, 4, 1);
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;

    // asynchronous reset mid-window
    pulse_start();
    send(5, 0); send(5, 0); send(5, 0);
    check("e_partial_sum", 32'(bus.sum_abs_err), 32'd15);
    #2 rst_n = 1'b0;
    #1;
    check("e_rst_ready", 32'(bus.in_ready), 32'd0);
    check("e_rst_valid", 32'(bus.out_valid), 32'd0);
    check("e_rst_sum",   32'(bus.sum_abs_err), 32'd0);
    check("e_rst_count", 32'(bus.err_count), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    send(9, 0);
    tick(); tick();
    check("e_no_report", 32'(bus.out_valid), 32'd0);
    check("e_no_absorb", 32'(bus.sum_abs_err), 32'd0);
    pulse_start();
    for (int i = 0; i < 4; i++) send(-3, 0);
    check_report("e", 12, 4, 3);
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    check("e_final_idle", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
